// File: rtl/sync_edge_filter_if.sv
// rtl/sync_edge_filter_if.sv - data/edge-pulse bundle for sync_edge_filter
interface sync_edge_filter_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] data_i;
    logic [WIDTH-1:0] data_o;
    logic [WIDTH-1:0] rise_o;
    logic [WIDTH-1:0] fall_o;

    modport master (
        output data_i,
        input  data_o,
        input  rise_o,
        input  fall_o
    );

    modport slave (
        input  data_i,
        output data_o,
        output rise_o,
        output fall_o
    );
endinterface

// File: rtl/sync_edge_filter.sv
// rtl/sync_edge_filter.sv - multi-channel synchronizer with edge pulses; optional glitch filter under SYNC_FILTER_EN
module sync_edge_filter #(
    parameter int WIDTH         = 1,
    parameter int STAGES        = 2,
    parameter int RESET_STATE   = 0,
    parameter int FILTER_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    sync_edge_filter_if.slave    bus
);

    localparam logic RST_BIT = RESET_STATE[0];
    localparam logic [WIDTH-1:0] RST_VEC = {WIDTH{RST_BIT}};

    // Elaboration-time parameter sanity.
    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("sync_edge_filter: STAGES must be >= 2");
        end
`ifdef SYNC_FILTER_EN
        if (FILTER_CYCLES < 1) begin : g_bad_filter
            $error("sync_edge_filter: FILTER_CYCLES must be >= 1");
        end
`endif
    endgenerate

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] fall_d;

    assign s = sync_q[STAGES-1];

    // Synchronizer chain; reset flushes every stage so in-flight changes are dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < STAGES; k++) begin
                sync_q[k] <= RST_VEC;
            end
        end else begin
            sync_q[0] <= bus.data_i;
            for (int k = 1; k < STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

`ifdef SYNC_FILTER_EN
    localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // Per-channel stability counter: a change is accepted only after
    // FILTER_CYCLES consecutive samples disagree with the current output.
    always_comb begin
        data_d = data_q;
        for (int n = 0; n < WIDTH; n++) begin
            cnt_d[n] = '0;
            if (s[n] == data_q[n]) begin
                cnt_d[n] = '0;
            end else if (cnt_q[n] == CNT_LAST) begin
                data_d[n] = s[n];
                cnt_d[n]  = '0;
            end else begin
                cnt_d[n] = cnt_q[n] + 1'b1;
            end
        end
    end

    // Filter counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int n = 0; n < WIDTH; n++) begin
                cnt_q[n] <= '0;
            end
        end else begin
            for (int n = 0; n < WIDTH; n++) begin
                cnt_q[n] <= cnt_d[n];
            end
        end
    end
`else
    // Unfiltered: output simply tracks the last synchronizer stage.
    always_comb begin
        data_d = s;
    end
`endif

    // Edge detect against the current registered level so pulses align with data_o.
    always_comb begin
        rise_d = ~data_q &  data_d;
        fall_d =  data_q & ~data_d;
    end

    // Output level and pulse registers; reset forces quiet pulses and the reset level.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q <= RST_VEC;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            data_q <= data_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign bus.data_o = data_q;
    assign bus.rise_o = rise_q;
    assign bus.fall_o = fall_q;

endmodule

// File: tb/tb_sync_edge_filter.sv
// tb/tb_sync_edge_filter.sv - self-checking bench for sync_edge_filter
module tb_sync_edge_filter;

    localparam int A_ST = 2;
    localparam int A_FC = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    logic rst_c = 1'b0;

    sync_edge_filter_if #(.WIDTH(8)) if_a ();
    sync_edge_filter_if #(.WIDTH(4)) if_b ();
    sync_edge_filter_if #(.WIDTH(1)) if_c ();

    sync_edge_filter #(.WIDTH(8), .STAGES(A_ST), .RESET_STATE(0), .FILTER_CYCLES(A_FC))
        u_a (.clk(clk), .reset(rst_a), .bus(if_a));
    sync_edge_filter #(.WIDTH(4), .STAGES(3), .RESET_STATE(1), .FILTER_CYCLES(4))
        u_b (.clk(clk), .reset(rst_b), .bus(if_b));
    sync_edge_filter #(.WIDTH(1), .STAGES(4), .RESET_STATE(0), .FILTER_CYCLES(4))
        u_c (.clk(clk), .reset(rst_c), .bus(if_c));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one DUT for one edge; the others sit in reset.
    task automatic apply(input int sel, input logic rst, input logic [7:0] din);
        rst_a = (sel == 0) ? rst : 1'b0;
        rst_b = (sel == 1) ? rst : 1'b0;
        rst_c = (sel == 2) ? rst : 1'b0;
        if (sel == 0) if_a.data_i = din;
        if (sel == 1) if_b.data_i = din[3:0];
        if (sel == 2) if_c.data_i = din[0];
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] out_d(input int sel);
        case (sel)
            0:       return if_a.data_o;
            1:       return {4'h0, if_b.data_o};
            default: return {7'h0, if_c.data_o};
        endcase
    endfunction

    function automatic logic [7:0] out_r(input int sel);
        case (sel)
            0:       return if_a.rise_o;
            1:       return {4'h0, if_b.rise_o};
            default: return {7'h0, if_c.rise_o};
        endcase
    endfunction

    function automatic logic [7:0] out_f(input int sel);
        case (sel)
            0:       return if_a.fall_o;
            1:       return {4'h0, if_b.fall_o};
            default: return {7'h0, if_c.fall_o};
        endcase
    endfunction

    typedef struct {
        int         sel;
        logic       rst;
        logic [7:0] din;
        logic [7:0] exp_d;
        logic [7:0] exp_r;
        logic [7:0] exp_f;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int sel, input logic rst, input logic [7:0] din,
                       input logic [7:0] ed, input logic [7:0] er, input logic [7:0] ef);
        vec_t v;
        v.sel = sel; v.rst = rst; v.din = din;
        v.exp_d = ed; v.exp_r = er; v.exp_f = ef;
        tbl.push_back(v);
    endtask

    // Reference model for u_a: output is the input sample seen STAGES edges ago,
    // optionally only once it has disagreed with the output for FILTER_CYCLES samples.
    logic [7:0] m_hist[$];
    logic [7:0] m_data, m_rise, m_fall;
    int         m_run[8];

    task automatic model_step(input logic rst, input logic [7:0] din);
        logic [7:0] s, nd;
        if (!rst) begin
            m_hist = {};
            for (int i = 0; i < A_ST; i++) m_hist.push_front(8'h00);
            m_data = 8'h00; m_rise = 8'h00; m_fall = 8'h00;
            for (int b = 0; b < 8; b++) m_run[b] = 0;
        end else begin
            s  = m_hist[A_ST-1];
            nd = m_data;
`ifdef SYNC_FILTER_EN
            for (int b = 0; b < 8; b++) begin
                if (s[b] != m_data[b]) begin
                    m_run[b] = m_run[b] + 1;
                    if (m_run[b] >= A_FC) begin
                        nd[b] = s[b];
                        m_run[b] = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
`else
            nd = s;
`endif
            m_rise = ~m_data & nd;
            m_fall = m_data & ~nd;
            m_data = nd;
            m_hist.push_front(din);
            void'(m_hist.pop_back());
        end
    endtask

    initial begin
        int rises, falls, bad_seen;
        logic       r;
        logic [7:0] d;

        if_a.data_i = '0;
        if_b.data_i = '0;
        if_c.data_i = '0;

`ifndef SYNC_FILTER_EN
        // u_b: reset to 4'hF, quiet release, then a 1->0 fall with STAGES=3.
        for (int i = 0; i < 3; i++) add(1, 0, 8'h00, 8'h0F, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) add(1, 1, 8'h0F, 8'h0F, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) add(1, 1, 8'h00, 8'h0F, 8'h00, 8'h00);
        add(1, 1, 8'h00, 8'h00, 8'h00, 8'h0F);
        add(1, 1, 8'h00, 8'h00, 8'h00, 8'h00);
        // u_c: STAGES=4 rise latency of 5 edges.
        for (int i = 0; i < 2; i++) add(2, 0, 8'h00, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++) add(2, 1, 8'h01, 8'h00, 8'h00, 8'h00);
        add(2, 1, 8'h01, 8'h01, 8'h01, 8'h00);
        add(2, 1, 8'h01, 8'h01, 8'h00, 8'h00);
        // u_a: STAGES=2 rise latency of 3 edges.
        for (int i = 0; i < 2; i++) add(0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 2; i++) add(0, 1, 8'h01, 8'h00, 8'h00, 8'h00);
        add(0, 1, 8'h01, 8'h01, 8'h01, 8'h00);
        add(0, 1, 8'h01, 8'h01, 8'h00, 8'h00);
        // u_a: multi-channel 00->A5->5A.
        add(0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 2; i++) add(0, 1, 8'hA5, 8'h00, 8'h00, 8'h00);
        add(0, 1, 8'hA5, 8'hA5, 8'hA5, 8'h00);
        add(0, 1, 8'hA5, 8'hA5, 8'h00, 8'h00);
        for (int i = 0; i < 2; i++) add(0, 1, 8'h5A, 8'hA5, 8'h00, 8'h00);
        add(0, 1, 8'h5A, 8'h5A, 8'h5A, 8'hA5);
        add(0, 1, 8'h5A, 8'h5A, 8'h00, 8'h00);
        // u_a: reset mid-flight discards the change, then normal latency.
        add(0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
        add(0, 1, 8'h01, 8'h00, 8'h00, 8'h00);
        add(0, 1, 8'h01, 8'h00, 8'h00, 8'h00);
        add(0, 0, 8'h01, 8'h00, 8'h00, 8'h00);
        add(0, 1, 8'h01, 8'h00, 8'h00, 8'h00);
        add(0, 1, 8'h01, 8'h00, 8'h00, 8'h00);
        add(0, 1, 8'h01, 8'h01, 8'h01, 8'h00);
        add(0, 1, 8'h01, 8'h01, 8'h00, 8'h00);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].sel, tbl[i].rst, tbl[i].din);
            check($sformatf("vec%0d data_o", i), out_d(tbl[i].sel), tbl[i].exp_d);
            check($sformatf("vec%0d rise_o", i), out_r(tbl[i].sel), tbl[i].exp_r);
            check($sformatf("vec%0d fall_o", i), out_f(tbl[i].sel), tbl[i].exp_f);
        end
`else
        // Filter: 3-cycle glitch never reaches the output.
        apply(0, 0, 8'h00); apply(0, 0, 8'h00);
        bad_seen = 0;
        for (int i = 0; i < 11; i++) begin
            apply(0, 1, (i < 3) ? 8'h01 : 8'h00);
            if (if_a.data_o != 8'h00 || if_a.rise_o != 8'h00 || if_a.fall_o != 8'h00) bad_seen++;
        end
        check("glitch suppressed", bad_seen[7:0], 8'h00);
        // Filter: sustained change accepted after edge 6.
        for (int i = 1; i <= 7; i++) begin
            apply(0, 1, 8'h01);
            if (i == 5) check("filt edge5 data_o", if_a.data_o, 8'h00);
            if (i == 6) begin
                check("filt edge6 data_o", if_a.data_o, 8'h01);
                check("filt edge6 rise_o", if_a.rise_o, 8'h01);
            end
            if (i == 7) check("filt edge7 rise_o", if_a.rise_o, 8'h00);
        end
`endif

        // Toggle every cycle: unfiltered follows with one pulse per change, filtered holds.
        apply(0, 0, 8'h00); apply(0, 0, 8'h00);
        rises = 0; falls = 0;
        for (int i = 0; i < 14; i++) begin
            apply(0, 1, (i < 8 && (i % 2) == 0) ? 8'h01 : 8'h00);
            rises += int'(if_a.rise_o[0]);
            falls += int'(if_a.fall_o[0]);
        end
`ifdef SYNC_FILTER_EN
        check("toggle rises", rises[7:0], 8'd0);
        check("toggle falls", falls[7:0], 8'd0);
`else
        check("toggle rises", rises[7:0], 8'd4);
        check("toggle falls", falls[7:0], 8'd4);
`endif
        check("toggle final data_o", if_a.data_o, 8'h00);

        // Randomized run against the reference model.
        d = 8'h00;
        for (int i = 0; i < 800; i++) begin
            r = (i < 2) ? 1'b0 : (($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1);
            if ($urandom_range(0, 5) == 0) d = 8'($urandom);
            else if ($urandom_range(0, 7) == 0) d = d ^ (8'h1 << $urandom_range(0, 7));
            model_step(r, d);
            apply(0, r, d);
            check($sformatf("rand%0d data_o", i), if_a.data_o, m_data);
            check($sformatf("rand%0d rise_o", i), if_a.rise_o, m_rise);
            check($sformatf("rand%0d fall_o", i), if_a.fall_o, m_fall);
            check($sformatf("rand%0d rise&fall", i), if_a.rise_o & if_a.fall_o, 8'h00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
